// File: rtl/sd_emmc_controller_adma2_seq_pkg.sv
// rtl/sd_emmc_controller_adma2_seq_pkg.sv - ADMA2 sequencer shared types and constants
package sd_emmc_controller_adma2_seq_pkg;

  localparam int ATTR_VALID   = 0;
  localparam int ATTR_END     = 1;
  localparam int ATTR_INT     = 2;
  localparam int ATTR_ACT_LSB = 3;

  localparam logic [2:0] ACT_TRAN = 3'b100;
  localparam logic [2:0] ACT_LINK = 3'b110;

  typedef enum logic [1:0] {
    ST_STOP = 2'b00,
    ST_FDS  = 2'b01,
    ST_TFR  = 2'b11
  } adma_err_state_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH_AR,
    S_FETCH_R,
    S_DECODE,
    S_XFER_REQ,
    S_XFER_WAIT,
    S_NEXT,
    S_DONE,
    S_ERROR
  } adma_state_e;

  typedef struct packed {
    logic        is_tran;
    logic        is_link;
    logic        valid;
    logic        is_end;
    logic        is_int;
    logic [16:0] len17;
    logic        align_err;
  } adma_desc_t;

  // A zero length field encodes a full 64 KiB segment.
  function automatic logic [16:0] seg_len_of(input logic [15:0] len);
    return (len == 16'h0) ? 17'h10000 : {1'b0, len};
  endfunction

endpackage

// File: rtl/sd_emmc_adma2_desc_decode.sv
// rtl/sd_emmc_adma2_desc_decode.sv - combinational ADMA2 descriptor field decode
module sd_emmc_adma2_desc_decode
  import sd_emmc_controller_adma2_seq_pkg::*;
#(
  parameter bit LEN_ZERO_64K = 1'b1
) (
  input  logic [5:0]  attr_i,
  input  logic [15:0] len_i,
  input  logic [1:0]  addr_lo_i,
  output adma_desc_t  desc_o
);

  logic [2:0] act;
  logic       len_zero_bad;

  always_comb begin
    act          = attr_i[ATTR_ACT_LSB +: 3];
    len_zero_bad = !LEN_ZERO_64K && (len_i == 16'h0);
    desc_o.is_tran   = (act == ACT_TRAN);
    desc_o.is_link   = (act == ACT_LINK);
    desc_o.valid     = attr_i[ATTR_VALID];
    desc_o.is_end    = attr_i[ATTR_END];
    desc_o.is_int    = attr_i[ATTR_INT];
    desc_o.len17     = seg_len_of(len_i);
    // Segments must be word aligned in both address and byte count.
    desc_o.align_err = (|addr_lo_i) || (|len_i[1:0]) || len_zero_bad;
  end

endmodule

// File: rtl/sd_emmc_controller_adma2_seq.sv
// rtl/sd_emmc_controller_adma2_seq.sv - ADMA2 descriptor fetch/decode/segment sequencer
module sd_emmc_controller_adma2_seq
  import sd_emmc_controller_adma2_seq_pkg::*;
#(
  parameter int MAX_DESC     = 1024,
  parameter bit LEN_ZERO_64K = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        adma_start_i,
  input  logic [31:0] adma_base_addr_i,
  input  logic        adma_abort_i,
  output logic [31:0] axi_araddr_o,
  output logic [7:0]  axi_arlen_o,
  output logic        axi_arvalid_o,
  input  logic        axi_arready_i,
  input  logic [31:0] axi_rdata_i,
  input  logic [1:0]  axi_rresp_i,
  input  logic        axi_rvalid_i,
  output logic        axi_rready_o,
  input  logic        axi_rlast_i,
  output logic [31:0] seg_addr_o,
  output logic [16:0] seg_len_o,
  output logic        seg_valid_o,
  input  logic        seg_ready_i,
  input  logic        seg_done_i,
  output logic        adma_busy_o,
  output logic        adma_done_o,
  output logic        adma_int_o,
  output logic        adma_err_o,
  output logic [1:0]  adma_err_state_o,
  output logic [31:0] adma_sys_addr_o
);

  localparam int CW = $clog2(MAX_DESC + 1);

  adma_state_e     state_q, state_d;
  logic [31:0]     sys_addr_q, sys_addr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  adma_err_state_e err_state_q, err_state_d;
  logic [5:0]      attr_q, attr_d;
  logic [15:0]     len_q, len_d;
  logic [31:0]     w1_q, w1_d;
  logic            beat_q, beat_d;
  logic            abort_pend_q, abort_pend_d;
  logic [31:0]     seg_addr_q, seg_addr_d;
  logic [16:0]     seg_len_q, seg_len_d;
  logic            abort_any;
  adma_desc_t      desc;

  sd_emmc_adma2_desc_decode #(
    .LEN_ZERO_64K(LEN_ZERO_64K)
  ) u_decode (
    .attr_i   (attr_q),
    .len_i    (len_q),
    .addr_lo_i(w1_q[1:0]),
    .desc_o   (desc)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      sys_addr_q   <= '0;
      cnt_q        <= '0;
      err_state_q  <= ST_STOP;
      attr_q       <= '0;
      len_q        <= '0;
      w1_q         <= '0;
      beat_q       <= 1'b0;
      abort_pend_q <= 1'b0;
      seg_addr_q   <= '0;
      seg_len_q    <= '0;
    end else begin
      state_q      <= state_d;
      sys_addr_q   <= sys_addr_d;
      cnt_q        <= cnt_d;
      err_state_q  <= err_state_d;
      attr_q       <= attr_d;
      len_q        <= len_d;
      w1_q         <= w1_d;
      beat_q       <= beat_d;
      abort_pend_q <= abort_pend_d;
      seg_addr_q   <= seg_addr_d;
      seg_len_q    <= seg_len_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sys_addr_d   = sys_addr_q;
    cnt_d        = cnt_q;
    err_state_d  = err_state_q;
    attr_d       = attr_q;
    len_d        = len_q;
    w1_d         = w1_q;
    beat_d       = beat_q;
    abort_pend_d = abort_pend_q;
    seg_addr_d   = seg_addr_q;
    seg_len_d    = seg_len_q;
    // Abort may be a short level; remember it while draining a burst or segment.
    abort_any    = adma_abort_i || abort_pend_q;

    case (state_q)
      S_IDLE: begin
        abort_pend_d = 1'b0;
        if (adma_start_i) begin
          sys_addr_d  = adma_base_addr_i;
          cnt_d       = '0;
          err_state_d = ST_STOP;
          state_d     = S_FETCH_AR;
        end
      end
      S_FETCH_AR: begin
        if (axi_arready_i) begin
          // The counter tracks fetched descriptors, so the loop guard trips without an extra fetch.
          cnt_d   = cnt_q + 1'b1;
          beat_d  = 1'b0;
          state_d = S_FETCH_R;
          if (adma_abort_i) abort_pend_d = 1'b1;
        end else if (adma_abort_i) begin
          err_state_d = ST_STOP;
          state_d     = S_IDLE;
        end
      end
      S_FETCH_R: begin
        if (axi_rvalid_i) begin
          if (!beat_q) begin
            attr_d = axi_rdata_i[5:0];
            len_d  = axi_rdata_i[31:16];
            beat_d = 1'b1;
          end else begin
            w1_d = axi_rdata_i;
          end
          if (abort_any) begin
            abort_pend_d = 1'b1;
            if (axi_rlast_i) begin
              err_state_d = ST_STOP;
              state_d     = S_IDLE;
            end
          end else if (axi_rresp_i != 2'b00 || (axi_rlast_i && !beat_q)) begin
            err_state_d = ST_FDS;
            state_d     = S_ERROR;
          end else if (axi_rlast_i) begin
            state_d = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        if (adma_abort_i) begin
          err_state_d = ST_STOP;
          state_d     = S_IDLE;
        end else if (!desc.valid || cnt_q == CW'(MAX_DESC)) begin
          err_state_d = ST_FDS;
          state_d     = S_ERROR;
        end else if (desc.is_tran) begin
          if (desc.align_err) begin
            err_state_d = ST_TFR;
            state_d     = S_ERROR;
          end else begin
            seg_addr_d = w1_q;
            seg_len_d  = desc.len17;
            state_d    = S_XFER_REQ;
          end
        end else if (desc.is_link) begin
          sys_addr_d = w1_q;
          state_d    = desc.is_end ? S_DONE : S_FETCH_AR;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_XFER_REQ: begin
        if (adma_abort_i) begin
          err_state_d = ST_STOP;
          state_d     = S_IDLE;
        end else if (seg_ready_i) begin
          state_d = seg_done_i ? S_NEXT : S_XFER_WAIT;
        end
      end
      S_XFER_WAIT: begin
        if (adma_abort_i) abort_pend_d = 1'b1;
        if (seg_done_i) begin
          if (abort_any) begin
            err_state_d = ST_STOP;
            state_d     = S_IDLE;
          end else begin
            state_d = S_NEXT;
          end
        end
      end
      S_NEXT: begin
        if (adma_abort_i) begin
          err_state_d = ST_STOP;
          state_d     = S_IDLE;
        end else if (desc.is_end) begin
          state_d = S_DONE;
        end else begin
          sys_addr_d = sys_addr_q + 32'd8;
          state_d    = S_FETCH_AR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign axi_araddr_o     = sys_addr_q;
  assign axi_arlen_o      = 8'd1;
  assign axi_arvalid_o    = (state_q == S_FETCH_AR);
  assign axi_rready_o     = (state_q == S_FETCH_R);
  assign seg_addr_o       = seg_addr_q;
  assign seg_len_o        = seg_len_q;
  assign seg_valid_o      = (state_q == S_XFER_REQ);
  assign adma_busy_o      = (state_q != S_IDLE);
  assign adma_done_o      = (state_q == S_DONE);
  assign adma_int_o       = (state_q == S_NEXT) && desc.is_int && !adma_abort_i;
  assign adma_err_o       = (state_q == S_ERROR);
  assign adma_err_state_o = err_state_q;
  assign adma_sys_addr_o  = sys_addr_q;

endmodule

// File: tb/tb_sd_emmc_controller_adma2_seq.sv
// tb/tb_sd_emmc_controller_adma2_seq.sv - self-checking bench for the ADMA2 sequencer
module tb_sd_emmc_controller_adma2_seq;

  localparam int MAX_DESC = 1024;
  localparam int WAIT_MAX = 40000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        adma_start = 1'b0;
  logic [31:0] adma_base_addr = '0;
  logic        adma_abort = 1'b0;
  logic [31:0] axi_araddr;
  logic [7:0]  axi_arlen;
  logic        axi_arvalid;
  logic        axi_arready = 1'b0;
  logic [31:0] axi_rdata = '0;
  logic [1:0]  axi_rresp = '0;
  logic        axi_rvalid = 1'b0;
  logic        axi_rready;
  logic        axi_rlast = 1'b0;
  logic [31:0] seg_addr;
  logic [16:0] seg_len;
  logic        seg_valid;
  logic        seg_ready = 1'b0;
  logic        seg_done = 1'b0;
  logic        adma_busy, adma_done, adma_int, adma_err;
  logic [1:0]  adma_err_state;
  logic [31:0] adma_sys_addr;

  always #5 clk = ~clk;

  sd_emmc_controller_adma2_seq dut (
    .clk_i(clk), .rst_ni(rst_n),
    .adma_start_i(adma_start), .adma_base_addr_i(adma_base_addr), .adma_abort_i(adma_abort),
    .axi_araddr_o(axi_araddr), .axi_arlen_o(axi_arlen), .axi_arvalid_o(axi_arvalid),
    .axi_arready_i(axi_arready), .axi_rdata_i(axi_rdata), .axi_rresp_i(axi_rresp),
    .axi_rvalid_i(axi_rvalid), .axi_rready_o(axi_rready), .axi_rlast_i(axi_rlast),
    .seg_addr_o(seg_addr), .seg_len_o(seg_len), .seg_valid_o(seg_valid),
    .seg_ready_i(seg_ready), .seg_done_i(seg_done),
    .adma_busy_o(adma_busy), .adma_done_o(adma_done), .adma_int_o(adma_int),
    .adma_err_o(adma_err), .adma_err_state_o(adma_err_state), .adma_sys_addr_o(adma_sys_addr)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [logic [31:0]];
  logic        bad_en = 1'b0;
  logic [31:0] bad_addr = '0;
  logic        dma_hold = 1'b0;

  logic [31:0] ar_log[$];
  logic [48:0] seg_log[$];
  int          n_done, n_int, n_err, int_then_done, segv_seen;
  logic        int_prev = 1'b0;

  logic [31:0] exp_ar[$];
  logic [48:0] exp_seg[$];
  int          exp_int, exp_done, exp_err;
  logic [1:0]  exp_state;
  logic [31:0] exp_sys;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] mkw0(input logic [15:0] len, input logic [2:0] act,
                                       input logic i, input logic e, input logic v);
    return {len, 10'h0, act, i, e, v};
  endfunction

  task automatic wr(input logic [31:0] a, input logic [31:0] w0, input logic [31:0] w1);
    mem[a]         = w0;
    mem[a + 32'd4] = w1;
  endtask

  // Walks the descriptor chain in memory following the ADMA2 rules directly.
  function automatic void model(input logic [31:0] base);
    logic [31:0] a, w0, w1;
    logic [15:0] len;
    logic [2:0]  act;
    int          cnt;
    exp_ar.delete(); exp_seg.delete();
    exp_int = 0; exp_done = 0; exp_err = 0; exp_state = 2'b00; exp_sys = base;
    a = base; cnt = 0;
    for (int g = 0; g < 5000; g++) begin
      exp_ar.push_back(a);
      cnt++;
      w0 = rd(a); w1 = rd(a + 32'd4);
      if ((bad_en && a == bad_addr) || !w0[0] || cnt == MAX_DESC) begin
        exp_err = 1; exp_state = 2'b01; exp_sys = a; return;
      end
      len = w0[31:16]; act = w0[5:3];
      if (act == 3'b110) begin
        a = w1;
        if (w0[1]) begin exp_done = 1; exp_sys = a; return; end
        continue;
      end
      if (act == 3'b100) begin
        if (w1[1:0] != 2'b00 || len[1:0] != 2'b00) begin
          exp_err = 1; exp_state = 2'b11; exp_sys = a; return;
        end
        exp_seg.push_back({w1, (len == 16'h0) ? 17'h10000 : {1'b0, len}});
      end
      if (w0[2]) exp_int++;
      if (w0[1]) begin exp_done = 1; exp_sys = a; return; end
      a = a + 32'd8;
    end
  endfunction

  task automatic clear_logs();
    ar_log.delete(); seg_log.delete();
    n_done = 0; n_int = 0; n_err = 0; int_then_done = 0; segv_seen = 0;
  endtask

  task automatic start_chain(input logic [31:0] base);
    @(posedge clk); #1;
    adma_base_addr = base; adma_start = 1'b1;
    @(posedge clk); #1;
    adma_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    for (k = 0; k < WAIT_MAX; k++) begin
      if (!adma_busy) break;
      @(posedge clk); #1;
    end
    chk({tag, ":timeout"}, (k == WAIT_MAX), 1'b0);
  endtask

  task automatic run(input string tag, input logic [31:0] base);
    int mis;
    clear_logs();
    model(base);
    start_chain(base);
    wait_idle(tag);
    chk({tag, ":ar_n"}, ar_log.size(), exp_ar.size());
    mis = -1;
    for (int i = 0; i < ar_log.size() && i < exp_ar.size(); i++)
      if (mis < 0 && ar_log[i] !== exp_ar[i]) mis = i;
    chk({tag, ":ar_seq"}, mis, -1);
    chk({tag, ":seg_n"}, seg_log.size(), exp_seg.size());
    mis = -1;
    for (int i = 0; i < seg_log.size() && i < exp_seg.size(); i++)
      if (mis < 0 && seg_log[i] !== exp_seg[i]) mis = i;
    chk({tag, ":seg_seq"}, mis, -1);
    chk({tag, ":done"}, n_done, exp_done);
    chk({tag, ":int"}, n_int, exp_int);
    chk({tag, ":err"}, n_err, exp_err);
    chk({tag, ":err_state"}, adma_err_state, exp_state);
    chk({tag, ":sys_addr"}, adma_sys_addr, exp_sys);
  endtask

  task automatic build_random(input logic [31:0] base);
    logic [31:0] a, sa, tgt;
    logic [15:0] len;
    logic [2:0]  nop_act [6];
    logic        last, ib;
    int          n, kind;
    nop_act[0] = 3'b000; nop_act[1] = 3'b001; nop_act[2] = 3'b010;
    nop_act[3] = 3'b011; nop_act[4] = 3'b101; nop_act[5] = 3'b111;
    mem.delete();
    bad_en = ($urandom_range(0, 7) == 0);
    bad_addr = base;
    a = base;
    n = $urandom_range(1, 8);
    for (int i = 0; i < n; i++) begin
      last = (i == n - 1);
      kind = $urandom_range(0, 9);
      ib   = ($urandom_range(0, 3) == 0);
      if (kind < 5) begin
        len = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom_range(1, 16383) << 2);
        sa  = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(0, 11) == 0) sa[0] = 1'b1;
        if ($urandom_range(0, 11) == 0) len[1] = 1'b1;
        wr(a, mkw0(len, 3'b100, ib, last, 1'b1), sa);
        a = a + 32'd8;
      end else if (kind < 7 && !last) begin
        tgt = base + 32'((i + 1) * 256);
        wr(a, mkw0(16'($urandom), 3'b110, 1'b0, 1'b0, 1'b1), tgt);
        a = tgt;
      end else begin
        wr(a, mkw0(16'($urandom), nop_act[$urandom_range(0, 5)], ib, last,
                   ($urandom_range(0, 15) != 0)), $urandom);
        a = a + 32'd8;
      end
    end
  endtask

  // AXI read slave: two beats per accepted address, random handshake timing.
  initial begin
    logic        ar_hs, r_hs;
    logic [31:0] ar_a, a;
    logic [31:0] rq[$];
    int          beat;
    beat = 0;
    forever begin
      @(negedge clk);
      ar_hs = axi_arvalid && axi_arready;
      r_hs  = axi_rvalid && axi_rready;
      ar_a  = axi_araddr;
      @(posedge clk); #1;
      if (!rst_n) begin
        rq.delete(); beat = 0;
        axi_rvalid = 1'b0; axi_arready = 1'b0; axi_rlast = 1'b0; axi_rresp = 2'b00;
        continue;
      end
      if (ar_hs) begin ar_log.push_back(ar_a); rq.push_back(ar_a); end
      if (r_hs) begin
        if (beat == 1) begin void'(rq.pop_front()); beat = 0; end
        else beat = 1;
        axi_rvalid = 1'b0;
      end
      axi_arready = ($urandom_range(0, 1) == 1);
      if (rq.size() > 0 && !axi_rvalid && $urandom_range(0, 3) != 0) begin
        a = rq[0];
        axi_rdata  = (beat == 1) ? rd(a + 32'd4) : rd(a);
        axi_rresp  = (bad_en && a == bad_addr && beat == 1) ? 2'b10 : 2'b00;
        axi_rlast  = (beat == 1);
        axi_rvalid = 1'b1;
      end
    end
  end

  // DMA datapath: accepts segments and completes them after a random delay.
  initial begin
    logic        hs, dn, pend;
    logic [31:0] sa;
    logic [16:0] sl;
    int          dly;
    pend = 1'b0; dly = 0;
    forever begin
      @(negedge clk);
      hs = seg_valid && seg_ready; dn = seg_done; sa = seg_addr; sl = seg_len;
      @(posedge clk); #1;
      seg_ready = 1'b0; seg_done = 1'b0;
      if (!rst_n) begin pend = 1'b0; continue; end
      if (hs) begin
        seg_log.push_back({sa, sl});
        if (!dn) begin pend = 1'b1; dly = $urandom_range(0, 4); end
      end else if (pend) begin
        if (dly > 0) dly--;
        else if (!dma_hold) begin seg_done = 1'b1; pend = 1'b0; end
      end else if (seg_valid && $urandom_range(0, 1) == 1) begin
        seg_ready = 1'b1;
        if (!dma_hold && $urandom_range(0, 2) == 0) seg_done = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (adma_done) begin n_done++; if (int_prev) int_then_done++; end
        if (adma_int) n_int++;
        if (adma_err) n_err++;
        if (seg_valid) segv_seen++;
        int_prev = adma_int;
      end
    end
  end

  initial begin
    int k;
    #1;
    chk("rst:busy", adma_busy, 1'b0);
    chk("rst:outs", {axi_arvalid, axi_rready, seg_valid, adma_done, adma_int, adma_err}, 6'b0);
    chk("rst:arlen", axi_arlen, 8'd1);
    chk("rst:regs", {axi_araddr, seg_addr, seg_len, adma_err_state, adma_sys_addr}, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    mem.delete();
    wr(32'h1000, mkw0(16'h0200, 3'b100, 1'b0, 1'b1, 1'b1), 32'h8000_0000);
    run("single", 32'h1000);
    chk("single:ar0", ar_log[0], 32'h1000);
    chk("single:seg0", seg_log[0], {32'h8000_0000, 17'd512});
    chk("single:sys", adma_sys_addr, 32'h1000);

    mem.delete();
    wr(32'h3000, mkw0(16'h0, 3'b000, 1'b0, 1'b0, 1'b1), 32'h0);
    wr(32'h3008, mkw0(16'h0, 3'b100, 1'b0, 1'b0, 1'b1), 32'h9000_0000);
    wr(32'h3010, mkw0(16'h0, 3'b110, 1'b0, 1'b0, 1'b1), 32'h2000);
    wr(32'h2000, mkw0(16'h0040, 3'b100, 1'b1, 1'b1, 1'b1), 32'hA000_0000);
    run("chain", 32'h3000);
    chk("chain:len64k", seg_log[0][16:0], 17'h10000);
    chk("chain:ar_last", ar_log[3], 32'h2000);
    chk("chain:int_then_done", int_then_done, 1);

    mem.delete();
    wr(32'h4000, mkw0(16'h0, 3'b000, 1'b0, 1'b0, 1'b1), 32'h0);
    wr(32'h4008, 32'h0, 32'h0);
    run("invalid", 32'h4000);
    chk("invalid:state", adma_err_state, 2'b01);
    chk("invalid:sys", adma_sys_addr, 32'h4008);
    chk("invalid:no_seg", segv_seen, 0);

    mem.delete();
    wr(32'h5000, mkw0(16'h0100, 3'b100, 1'b0, 1'b1, 1'b1), 32'h8000_1000);
    bad_en = 1'b1; bad_addr = 32'h5000;
    run("rresp", 32'h5000);
    chk("rresp:state", adma_err_state, 2'b01);
    bad_en = 1'b0;

    mem.delete();
    wr(32'h5800, mkw0(16'h0202, 3'b100, 1'b0, 1'b1, 1'b1), 32'h8000_2000);
    run("tfr", 32'h5800);
    chk("tfr:state", adma_err_state, 2'b11);
    chk("tfr:no_seg", segv_seen, 0);

    mem.delete();
    wr(32'h6000, mkw0(16'h0, 3'b110, 1'b0, 1'b0, 1'b1), 32'h6000);
    run("selflink", 32'h6000);
    chk("selflink:fetches", ar_log.size(), MAX_DESC);
    chk("selflink:state", adma_err_state, 2'b01);

    for (int r = 0; r < 25; r++) begin
      logic [31:0] base;
      base = (r == 3) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_F000);
      build_random(base);
      run($sformatf("rand%0d", r), base);
    end
    bad_en = 1'b0;

    mem.delete();
    wr(32'h7000, mkw0(16'h0100, 3'b100, 1'b1, 1'b1, 1'b1), 32'hB000_0000);
    dma_hold = 1'b1;
    clear_logs();
    start_chain(32'h7000);
    for (k = 0; k < 2000 && seg_log.size() == 0; k++) begin @(posedge clk); #1; end
    chk("abort:seg_accepted", seg_log.size(), 1);
    adma_abort = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    chk("abort:held_busy", adma_busy, 1'b1);
    dma_hold = 1'b0;
    wait_idle("abort");
    adma_abort = 1'b0;
    chk("abort:pulses", {n_done[7:0], n_int[7:0], n_err[7:0]}, 24'h0);
    chk("abort:state", adma_err_state, 2'b00);

    mem.delete();
    wr(32'h8000, mkw0(16'h0100, 3'b100, 1'b0, 1'b1, 1'b1), 32'hC000_0000);
    clear_logs();
    start_chain(32'h8000);
    for (k = 0; k < 2000 && !axi_rready; k++) begin @(posedge clk); #1; end
    chk("arst:in_fetch_r", axi_rready, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst:flags", {adma_busy, axi_arvalid, axi_rready, seg_valid, adma_done, adma_int, adma_err}, 7'b0);
    chk("arst:regs", {axi_araddr, adma_sys_addr, adma_err_state, seg_addr, seg_len}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run("post_reset", 32'h8000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
